// File: rtl/line_pkg.sv
// Shared types and width constants for the Bresenham line engine.
package line_pkg;

    // Default signed coordinate width for x and y
    localparam int COORD_W_DEF = 11;

    // Error accumulator and doubled-error widths at the default coordinate width
    localparam int ERR_W = COORD_W_DEF + 2;
    localparam int E2_W  = COORD_W_DEF + 3;

    typedef logic signed [COORD_W_DEF-1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        DRAW,
        WAIT
    } state_t;

    // Accumulator width for a given coordinate width
    function automatic int err_w(input int cw);
        return cw + 2;
    endfunction

    // Doubled-error width for a given coordinate width
    function automatic int e2_w(input int cw);
        return cw + 3;
    endfunction

endpackage

// File: rtl/step_divider.sv
// Step pacing counter: ticks on the DIV-1'th enabled cycle after a clear.
module step_divider #(
    parameter int unsigned DIV = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_en,
    output logic o_tick
);

    localparam int unsigned CNT_W = $clog2(DIV) + 1;
    // Count value seen on the last enabled cycle of a period
    localparam logic [CNT_W-1:0] LAST = (DIV >= 2) ? CNT_W'(DIV - 2) : '0;

    logic [CNT_W-1:0] r_cnt;

    assign o_tick = i_en && (r_cnt == LAST);

    // Counter advances while enabled and wraps on the tick
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tick ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/bresenham_line_engine.sv
// Bresenham line rasteriser with paced, back-pressured pixel output.
module bresenham_line_engine
    import line_pkg::*;
#(
    parameter int          COORD_W  = COORD_W_DEF,
    parameter int unsigned STEP_DIV = 750000
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_start,
    input  logic                      i_abort,
    input  logic signed [COORD_W-1:0] i_x0,
    input  logic signed [COORD_W-1:0] i_y0,
    input  logic signed [COORD_W-1:0] i_x1,
    input  logic signed [COORD_W-1:0] i_y1,
    input  logic                      i_color_in,
    input  logic                      i_pix_ready,
    output logic                      o_pix_valid,
    output logic signed [COORD_W-1:0] o_pix_x,
    output logic signed [COORD_W-1:0] o_pix_y,
    output logic                      o_pix_color,
    output logic                      o_busy,
    output logic                      o_done
);

    localparam int DW    = COORD_W + 1;
    localparam int ACC_W = err_w(COORD_W);
    localparam int DBL_W = e2_w(COORD_W);

    state_t                    r_state;
    logic signed [COORD_W-1:0] r_x0;
    logic signed [COORD_W-1:0] r_y0;
    logic signed [COORD_W-1:0] r_x1;
    logic signed [COORD_W-1:0] r_y1;
    logic signed [DW-1:0]      r_dx;     // |x1-x0|
    logic signed [DW-1:0]      r_dy;     // -|y1-y0|
    logic                      r_sx_neg;
    logic                      r_sy_neg;
    logic signed [ACC_W-1:0]   r_err;

    logic signed [DW-1:0]      w_dx_raw;
    logic signed [DW-1:0]      w_dy_raw;
    logic signed [DW-1:0]      w_dx_abs;
    logic signed [DW-1:0]      w_dy_nabs;
    logic signed [ACC_W-1:0]   w_err_init;
    logic signed [DBL_W-1:0]   w_e2;
    logic                      w_step_x;
    logic                      w_step_y;
    logic signed [ACC_W-1:0]   w_err_nxt;
    logic signed [COORD_W-1:0] w_x_nxt;
    logic signed [COORD_W-1:0] w_y_nxt;
    logic                      w_at_end;
    logic                      w_div_en;
    logic                      w_div_clear;
    logic                      w_tick;

    // Setup deltas and per-step decision from the latched endpoints and error term
    always_comb begin
        w_dx_raw   = DW'(r_x1) - DW'(r_x0);
        w_dy_raw   = DW'(r_y1) - DW'(r_y0);
        w_dx_abs   = w_dx_raw[DW-1] ? -w_dx_raw : w_dx_raw;
        w_dy_nabs  = w_dy_raw[DW-1] ? w_dy_raw : -w_dy_raw;
        w_err_init = ACC_W'(w_dx_abs) + ACC_W'(w_dy_nabs);

        w_e2      = $signed({r_err, 1'b0});
        w_step_x  = (w_e2 >= DBL_W'(r_dy));
        w_step_y  = (w_e2 <= DBL_W'(r_dx));
        w_err_nxt = r_err;
        if (w_step_x) begin
            w_err_nxt = w_err_nxt + ACC_W'(r_dy);
        end
        if (w_step_y) begin
            w_err_nxt = w_err_nxt + ACC_W'(r_dx);
        end

        w_x_nxt  = o_pix_x + (r_sx_neg ? {COORD_W{1'b1}} : COORD_W'(1));
        w_y_nxt  = o_pix_y + (r_sy_neg ? {COORD_W{1'b1}} : COORD_W'(1));
        w_at_end = (o_pix_x == r_x1) && (o_pix_y == r_y1);
    end

    // Divider only runs in WAIT, so it is already cleared on every entry
    assign w_div_en    = (r_state == WAIT);
    assign w_div_clear = (r_state != WAIT);

    step_divider #(
        .DIV (STEP_DIV)
    ) u_step_divider (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (w_div_clear),
        .i_en    (w_div_en),
        .o_tick  (w_tick)
    );

    // Control FSM with registered outputs; abort beats start and the handshake
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_x0        <= '0;
            r_y0        <= '0;
            r_x1        <= '0;
            r_y1        <= '0;
            r_dx        <= '0;
            r_dy        <= '0;
            r_sx_neg    <= 1'b0;
            r_sy_neg    <= 1'b0;
            r_err       <= '0;
            o_pix_valid <= 1'b0;
            o_pix_x     <= '0;
            o_pix_y     <= '0;
            o_pix_color <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else if (i_abort) begin
            r_state     <= IDLE;
            o_pix_valid <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            o_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_x0        <= i_x0;
                        r_y0        <= i_y0;
                        r_x1        <= i_x1;
                        r_y1        <= i_y1;
                        o_pix_color <= i_color_in;
                        o_busy      <= 1'b1;
                        r_state     <= SETUP;
                    end
                end
                SETUP: begin
                    r_dx        <= w_dx_abs;
                    r_dy        <= w_dy_nabs;
                    r_sx_neg    <= !(r_x0 < r_x1);
                    r_sy_neg    <= !(r_y0 < r_y1);
                    r_err       <= w_err_init;
                    o_pix_x     <= r_x0;
                    o_pix_y     <= r_y0;
                    o_pix_valid <= 1'b1;
                    r_state     <= DRAW;
                end
                DRAW: begin
                    if (i_pix_ready) begin
                        if (w_at_end) begin
                            o_pix_valid <= 1'b0;
                            o_busy      <= 1'b0;
                            o_done      <= 1'b1;
                            r_state     <= IDLE;
                        end else begin
                            if (w_step_x) begin
                                o_pix_x <= w_x_nxt;
                            end
                            if (w_step_y) begin
                                o_pix_y <= w_y_nxt;
                            end
                            r_err <= w_err_nxt;
                            if (STEP_DIV > 1) begin
                                o_pix_valid <= 1'b0;
                                r_state     <= WAIT;
                            end
                        end
                    end
                end
                WAIT: begin
                    if (w_tick) begin
                        o_pix_valid <= 1'b1;
                        r_state     <= DRAW;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bresenham_line_engine.sv
// Self-checking bench: two engines (one step per cycle, and four cycles per step)
// driven by directed and random lines, compared against an integer line model.
module tb_bresenham_line_engine;
    import line_pkg::*;

    localparam int STEP0 = 1;
    localparam int STEP1 = 4;

    logic   clk = 1'b0;
    logic   reset;
    logic   start [2];
    logic   abort_r [2];
    logic   ready [2];
    logic   color [2];
    coord_t x0 [2];
    coord_t y0 [2];
    coord_t x1 [2];
    coord_t y1 [2];
    logic   pv [2];
    logic   pc [2];
    logic   busy [2];
    logic   done [2];
    coord_t px [2];
    coord_t py [2];

    int checks = 0;
    int errors = 0;
    int exp_x [$];
    int exp_y [$];

    always #5 clk = ~clk;

    bresenham_line_engine #(
        .COORD_W  (COORD_W_DEF),
        .STEP_DIV (STEP0)
    ) u_dut0 (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_start     (start[0]),
        .i_abort     (abort_r[0]),
        .i_x0        (x0[0]),
        .i_y0        (y0[0]),
        .i_x1        (x1[0]),
        .i_y1        (y1[0]),
        .i_color_in  (color[0]),
        .i_pix_ready (ready[0]),
        .o_pix_valid (pv[0]),
        .o_pix_x     (px[0]),
        .o_pix_y     (py[0]),
        .o_pix_color (pc[0]),
        .o_busy      (busy[0]),
        .o_done      (done[0])
    );

    bresenham_line_engine #(
        .COORD_W  (COORD_W_DEF),
        .STEP_DIV (STEP1)
    ) u_dut1 (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_start     (start[1]),
        .i_abort     (abort_r[1]),
        .i_x0        (x0[1]),
        .i_y0        (y0[1]),
        .i_x1        (x1[1]),
        .i_y1        (y1[1]),
        .i_color_in  (color[1]),
        .i_pix_ready (ready[1]),
        .o_pix_valid (pv[1]),
        .o_pix_x     (px[1]),
        .o_pix_y     (py[1]),
        .o_pix_color (pc[1]),
        .o_busy      (busy[1]),
        .o_done      (done[1])
    );

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference raster: the classic integer Bresenham walk, endpoint inclusive
    task automatic build_model(input int ax0, input int ay0, input int ax1, input int ay1);
        int x, y, dx, dy, sx, sy, err, e2;
        exp_x.delete();
        exp_y.delete();
        dx  = iabs(ax1 - ax0);
        dy  = -iabs(ay1 - ay0);
        sx  = (ax0 < ax1) ? 1 : -1;
        sy  = (ay0 < ay1) ? 1 : -1;
        err = dx + dy;
        x   = ax0;
        y   = ay0;
        for (int k = 0; k < 5000; k++) begin
            exp_x.push_back(x);
            exp_y.push_back(y);
            if (x == ax1 && y == ay1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin
                err += dy;
                x   += sx;
            end
            if (e2 <= dx) begin
                err += dx;
                y   += sy;
            end
        end
    endtask

    task automatic draw_line(input int d, input int ax0, input int ay0, input int ax1,
                             input int ay1, input logic col, input int stall_pct,
                             input int stall_idx, input int stall_len, input bit poke);
        int     n, idx, cyc, last_hs, scnt, budget, step, npix;
        logic   r;
        bit     held;
        coord_t hx, hy;
        build_model(ax0, ay0, ax1, ay1);
        n      = exp_x.size();
        npix   = ((iabs(ax1 - ax0) > iabs(ay1 - ay0)) ? iabs(ax1 - ax0) : iabs(ay1 - ay0)) + 1;
        step   = (d == 0) ? STEP0 : STEP1;
        budget = n * step * 8 + 64;
        @(negedge clk);
        x0[d]    = coord_t'(ax0);
        y0[d]    = coord_t'(ay0);
        x1[d]    = coord_t'(ax1);
        y1[d]    = coord_t'(ay1);
        color[d] = col;
        start[d] = 1'b1;
        ready[d] = 1'b0;
        @(negedge clk);
        start[d] = 1'b0;
        chk("setup_busy", busy[d], 1);
        chk("setup_valid", pv[d], 0);
        idx     = 0;
        cyc     = 0;
        last_hs = 0;
        scnt    = 0;
        held    = 1'b0;
        hx      = '0;
        hy      = '0;
        while (idx < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (poke && cyc == 3) begin
                start[d] = 1'b1;
                x0[d]    = coord_t'($urandom_range(200));
                y0[d]    = coord_t'($urandom_range(200));
                x1[d]    = coord_t'($urandom_range(200));
                y1[d]    = coord_t'($urandom_range(200));
                color[d] = ~col;
            end else begin
                start[d] = 1'b0;
            end
            if (held) begin
                chk("stall_hold_valid", pv[d], 1);
                chk("stall_hold_x", px[d], hx);
                chk("stall_hold_y", py[d], hy);
            end
            if (pv[d] && idx == stall_idx && scnt < stall_len) begin
                r = 1'b0;
                scnt++;
            end else if (stall_pct > 0) begin
                r = ($urandom_range(99) >= stall_pct);
            end else begin
                r = 1'b1;
            end
            ready[d] = r;
            held     = pv[d] && !r;
            hx       = px[d];
            hy       = py[d];
            if (pv[d]) begin
                chk("draw_busy", busy[d], 1);
            end
            if (pv[d] && r) begin
                chk("pix_x", px[d], exp_x[idx]);
                chk("pix_y", py[d], exp_y[idx]);
                chk("pix_color", pc[d], col);
                if (idx > 0 && stall_pct == 0 && stall_idx < 0) begin
                    chk("pix_spacing", cyc - last_hs, step);
                end
                last_hs = cyc;
                idx++;
            end
        end
        start[d] = 1'b0;
        chk("pix_count", idx, npix);
        @(negedge clk);
        ready[d] = 1'b0;
        chk("done_pulse", done[d], 1);
        chk("done_busy_low", busy[d], 0);
        chk("done_valid_low", pv[d], 0);
        @(negedge clk);
        chk("done_one_cycle", done[d], 0);
    endtask

    initial begin
        bit found;
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            start[d]   = 1'b0;
            abort_r[d] = 1'b0;
            ready[d]   = 1'b0;
            color[d]   = 1'b0;
            x0[d]      = '0;
            y0[d]      = '0;
            x1[d]      = '0;
            y1[d]      = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_valid", pv[d], 0);
            chk("rst_busy", busy[d], 0);
            chk("rst_done", done[d], 0);
            chk("rst_x", px[d], 0);
            chk("rst_y", py[d], 0);
        end
        reset = 1'b0;

        // Directed lines
        draw_line(0, 0, 0, 5, 2, 1'b1, 0, -1, 0, 1'b0);
        draw_line(1, 100, 100, 95, 120, 1'b1, 0, -1, 0, 1'b0);
        draw_line(1, 10, 10, 10, 10, 1'b0, 0, -1, 0, 1'b0);
        draw_line(0, 0, 0, 4, 0, 1'b1, 0, 2, 3, 1'b0);

        // Abort while pacing between pixels
        @(negedge clk);
        x0[1] = '0;
        y0[1] = '0;
        x1[1] = coord_t'(639);
        y1[1] = coord_t'(479);
        color[1] = 1'b1;
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        ready[1] = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (pv[1]) begin
                found = 1'b1;
                break;
            end
        end
        chk("abort_first_pixel", found, 1);
        @(negedge clk);
        chk("wait_busy", busy[1], 1);
        chk("wait_valid", pv[1], 0);
        abort_r[1] = 1'b1;
        @(negedge clk);
        abort_r[1] = 1'b0;
        ready[1]   = 1'b0;
        chk("abort_busy", busy[1], 0);
        chk("abort_valid", pv[1], 0);
        chk("abort_done", done[1], 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("abort_no_done", done[1], 0);
        end
        draw_line(1, 20, 20, 25, 25, 1'b1, 0, -1, 0, 1'b0);

        // Reset mid-line
        @(negedge clk);
        x0[0] = '0;
        y0[0] = '0;
        x1[0] = coord_t'(30);
        y1[0] = coord_t'(7);
        color[0] = 1'b1;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        ready[0] = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_valid", pv[0], 0);
        chk("midrst_busy", busy[0], 0);
        chk("midrst_done", done[0], 0);
        chk("midrst_x", px[0], 0);
        chk("midrst_y", py[0], 0);
        chk("midrst_color", pc[0], 0);
        reset    = 1'b0;
        ready[0] = 1'b0;

        // start during DRAW must be ignored
        draw_line(0, -5, 3, 12, -9, 1'b1, 0, -1, 0, 1'b1);

        // Random lines, with and without random back-pressure
        for (int i = 0; i < 8; i++) begin
            draw_line(i % 2,
                      int'($urandom_range(300)) - 150, int'($urandom_range(300)) - 150,
                      int'($urandom_range(300)) - 150, int'($urandom_range(300)) - 150,
                      logic'($urandom_range(1)), (i >= 4) ? 30 : 0, -1, 0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bresenham_line_engine.md
# bresenham_line_engine

Parametrised Bresenham line rasteriser. It draws a line between two arbitrary endpoints, latched when `start` is asserted, and emits one pixel per accepted handshake. A programmable step divider sets the drawing speed for visible animation, and `pix_ready` lets the caller back-pressure the output. It sits between the game/control FSM and the VGA framebuffer write port, and replaces the fixed-speed, edge-only line drawer.

## Interface
- `COORD_W`, 11: signed coordinate width (x and y).
- `STEP_DIV`, 750000: clock cycles between successive pixel steps. Must be ≥1; 1 means one step per cycle.
- `clk`  in  1: system clock (50 MHz).
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: request to draw. Sampled only in IDLE.
- `abort`  in  1: synchronous cancel. Returns to IDLE from any state.
- `x0`, `y0`, `x1`, `y1`  in  COORD_W signed: endpoints, latched on the accepted `start`.
- `color_in`  in  1: draw (1) or erase (0). Latched with the endpoints.
- `pix_ready`  in  1: consumer accepts the pixel this cycle.
- `pix_valid`  out  1: `pix_x`/`pix_y`/`pix_color` are valid.
- `pix_x`, `pix_y`  out  COORD_W signed: current pixel.
- `pix_color`  out  1: latched `color_in`.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse after the final pixel is accepted.

## Operation
- **States:** IDLE, SETUP, DRAW, WAIT.
- **IDLE:** if `start` is high, latch the endpoints and colour, then go to SETUP. `start` is ignored in all other states.
- **SETUP (1 cycle):**
  - dx = |x1−x0|, dy = −|y1−y0|, both COORD_W+1 signed.
  - sx = (x0<x1) ? +1 : −1; sy = (y0<y1) ? +1 : −1.
  - err = dx+dy (COORD_W+2 signed).
  - Load x/y from x0/y0.
  - Go to DRAW.
- **DRAW:** `pix_valid`=1. Hold all outputs stable until `pix_ready` is high.
  - On handshake with x==x1 and y==y1: pulse `done`, go to IDLE.
  - On handshake otherwise: compute e2 = 2·err (COORD_W+3 signed).
    - If e2 ≥ dy: x += sx, err += dy.
    - If e2 ≤ dx: y += sy, err += dx.
    - When both conditions hold, both updates apply in the same cycle: err += dx+dy.
    - Then go to WAIT, or stay in DRAW when STEP_DIV==1.
- **WAIT:** the divider counts STEP_DIV−1 cycles, then goes to DRAW. The counter clears on entry.
- **Pixel count:** exactly max(dx, −dy)+1 handshakes per line.
- **Degenerate cases:**
  - Single point (x0==x1, y0==y1): one pixel, then `done`.
  - Vertical and horizontal lines need no special handling.
- **abort:** go to IDLE next cycle; `pix_valid`/`busy` drop; no `done`. `abort` has priority over `start` and over the handshake.
- **reset:**
  - All outputs go to 0, state to IDLE, divider to 0.
  - Reset mid-line discards the line.
  - Reset has priority over `abort`.

## Timing
- `start` high at edge t puts SETUP in t→t+1. First `pix_valid` is at t+2.
- With `pix_ready` tied high, consecutive pixels are STEP_DIV cycles apart.
- `done` asserts the cycle after the final handshake, coincident with `busy`=0.
- A new `start` is accepted in that same cycle (IDLE). There are no dead cycles beyond this.
- Outputs are all registered. `pix_valid` must not depend combinationally on `pix_ready`.

## Structure
- **Package `line_pkg`:**
  - `state_t` enum {IDLE, SETUP, DRAW, WAIT}.
  - `coord_t` typedef (logic signed [COORD_W-1:0]) with COORD_W as a package parameter default.
  - Error-width constants ERR_W = COORD_W+2 and E2_W = COORD_W+3.
- **Sub-module `step_divider`:**
  - Parameter DIV.
  - Inputs `clk`, `reset`, `clear`, `en`; output `tick` after DIV−1 enabled cycles.
  - Counter width is $clog2(DIV)+1.
- The top FSM and datapath stay in `bresenham_line_engine`.

## Test plan
- STEP_DIV=1, `pix_ready`=1, (0,0)→(5,2) → six pixels (0,0),(1,0),(2,1),(3,1),(4,2),(5,2); `done` one cycle after the last.
- STEP_DIV=4, (100,100)→(95,120), steep left-down → 21 pixels, y strictly +1 per pixel, pixels exactly 4 cycles apart, final (95,120).
- (10,10)→(10,10) → exactly one pixel (10,10), then `done`; `busy` high for 2 cycles before the pixel plus 1.
- (0,0)→(4,0) with `pix_ready` low 3 cycles on pixel 2 → `pix_x`=2 held stable while stalled; total 5 pixels, no skips.
- `abort` during WAIT of (0,0)→(639,479) → IDLE next cycle, no `done`; following `start` (20,20)→(25,25) draws correctly from (20,20).
- `reset` mid-line → all outputs 0 next cycle; `start` asserted during DRAW → ignored, line unchanged.
